// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: default bus widths
// and the arbiter state encoding.
package wb_pkg;

  localparam int DAT_WIDTH_DEF = 64;
  localparam int ADR_WIDTH_DEF = 64;
  localparam int SEL_WIDTH_DEF = DAT_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Ownership state that corresponds to granting the given master.
  function automatic arb_state_e own_state(input logic master);
    if (master) begin
      return ARB_OWN1;
    end else begin
      return ARB_OWN0;
    end
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog for wb_arbiter (only instantiated when WB_ARB_TIMEOUT_EN is
// defined). Counts consecutive cycles where a strobe is outstanding and the
// slave neither acks nor errors; flags timeout_o for one cycle when the count
// reaches TIMEOUT_CYCLES, then restarts from zero.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign timeout_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next count: clear after a timeout or any slave response, else count stalls.
  always_comb begin
    cnt_d = cnt_q;
    if (timeout_o) begin
      cnt_d = '0;
    end else if (stb_i && !ack_i && !err_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter. A master that raises cyc while the
// bus is idle is granted on the next edge; simultaneous requests alternate
// round-robin using last_owner. The owner keeps the bus until it drops cyc,
// after which one idle cycle passes before the next grant. The slave-side
// signals are a combinational mux of the owner's inputs.
// Optional: define WB_ARB_TIMEOUT_EN to add a watchdog that returns an error
// to the owner when the slave stays silent for TIMEOUT_CYCLES strobed cycles.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DAT_WIDTH      = DAT_WIDTH_DEF,
  parameter int ADR_WIDTH      = ADR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // master 0
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [DAT_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADR_WIDTH-1:0]   m0_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_dat_i,
  output logic [DAT_WIDTH-1:0]   m0_dat_o,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  // master 1
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [DAT_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADR_WIDTH-1:0]   m1_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_dat_i,
  output logic [DAT_WIDTH-1:0]   m1_dat_o,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  // slave
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [DAT_WIDTH/8-1:0] s_sel_o,
  output logic [ADR_WIDTH-1:0]   s_adr_o,
  output logic [DAT_WIDTH-1:0]   s_dat_o,
  input  logic [DAT_WIDTH-1:0]   s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_owner_q;
  logic       last_owner_d;
  logic       timeout_s;
  logic       own0_s;
  logic       own1_s;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .stb_i    (s_stb_o),
    .ack_i    (s_ack_i),
    .err_i    (s_err_i),
    .timeout_o(timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Grant decision: hold ownership while cyc stays high, round-robin on ties.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = own_state(~last_owner_q);
        end else if (m0_cyc_i) begin
          state_d = ARB_OWN0;
        end else if (m1_cyc_i) begin
          state_d = ARB_OWN1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_OWN0: begin
        if (!m0_cyc_i) begin
          state_d      = ARB_IDLE;
          last_owner_d = 1'b0;
        end else begin
          state_d = ARB_OWN0;
        end
      end
      ARB_OWN1: begin
        if (!m1_cyc_i) begin
          state_d      = ARB_IDLE;
          last_owner_d = 1'b1;
        end else begin
          state_d = ARB_OWN1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state; reset leaves m1 as last owner so m0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign own0_s = (state_q == ARB_OWN0);
  assign own1_s = (state_q == ARB_OWN1);

  // Slave-side mux: only the owner's signals reach the slave; idle bus is quiet.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state_q)
      ARB_OWN0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      ARB_OWN1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
      end
    endcase
  end

  // Response routing: a real ack wins over a same-cycle watchdog timeout.
  always_comb begin
    m0_ack_o = own0_s & s_ack_i;
    m1_ack_o = own1_s & s_ack_i;
    m0_err_o = own0_s & (s_err_i | (timeout_s & ~s_ack_i));
    m1_err_o = own1_s & (s_err_i | (timeout_s & ~s_ack_i));
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference model of bus ownership pushes
// the expected slave-side view for each cycle in which the bus should show
// activity; a monitor on the falling edge pops and compares whenever the DUT
// shows activity. Directed sequences cover reset, ties, no-preemption, read
// data routing, reset mid-transfer and (with WB_ARB_TIMEOUT_EN) the watchdog.
module tb_wb_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [1:0]    cyc = 2'b00;
  logic [1:0]    stb = 2'b00;
  logic [1:0]    we = 2'b00;
  logic [SW-1:0] sel [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wdat [2];
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i = 1'b0;
  logic          s_err_i = 1'b0;

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0] s_sel_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;

  typedef struct {
    int            cyc_no;
    logic          cyc, stb, we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat, rdat;
    logic          ack0, ack1, err0, err1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_no = 0;
  int   owner = -1;       // -1: nobody owns the bus
  int   last_owner = 1;
  int   wd = 0;
  logic force_we = 1'b0;
  logic [1:0] rc = 2'b00;

  wb_arbiter #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle_no);
    end
  endtask

  // Ownership rules applied at a rising edge, using inputs held over the last cycle.
  function automatic void model_edge();
    if (!rst_i) begin
      owner = -1; last_owner = 1; wd = 0;
      return;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (wd == TO) wd = 0;
    else if (owner >= 0 && stb[owner] && !s_ack_i && !s_err_i) wd = wd + 1;
    else wd = 0;
`endif
    if (owner < 0) begin
      if (cyc == 2'b11) owner = 1 - last_owner;
      else if (cyc[0]) owner = 0;
      else if (cyc[1]) owner = 1;
    end else if (!cyc[owner]) begin
      last_owner = owner;
      owner = -1;
    end
  endfunction

  // Expected bus view for the current cycle; queued only when activity is due.
  function automatic void publish();
    exp_t e;
    logic to_hit;
    logic err;
    if (!rst_i || owner < 0) return;
    to_hit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    to_hit = (wd == TO);
`endif
    err = s_err_i | (to_hit & !s_ack_i);
    e.cyc_no = cycle_no;
    e.cyc = cyc[owner]; e.stb = stb[owner]; e.we = we[owner];
    e.sel = sel[owner]; e.adr = adr[owner]; e.wdat = wdat[owner];
    e.rdat = s_dat_i;
    e.ack0 = (owner == 0) && s_ack_i;
    e.ack1 = (owner == 1) && s_ack_i;
    e.err0 = (owner == 0) && err;
    e.err1 = (owner == 1) && err;
    if (e.cyc || s_ack_i || err) sb_q.push_back(e);
  endfunction

  // One clock cycle of stimulus: model steps at the edge, new inputs 1 unit later.
  task automatic apply(input logic c0, input logic c1, input logic s0, input logic s1,
                       input logic ack, input logic err, input logic [63:0] sdat);
    @(posedge clk);
    model_edge();
    #1;
    cycle_no++;
    cyc = {c1, c0};
    stb = {s1 & c1, s0 & c0};
    for (int i = 0; i < 2; i++) begin
      we[i]   = force_we ? 1'b1 : 1'($urandom);
      sel[i]  = SW'($urandom);
      adr[i]  = {$urandom, $urandom};
      wdat[i] = {$urandom, $urandom};
    end
    s_ack_i = ack;
    s_err_i = err;
    s_dat_i = sdat;
    publish();
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: compare DUT activity against the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic pres;
    if (rst_i) begin
      while (sb_q.size() > 0 && sb_q[0].cyc_no < cycle_no) begin
        checks++; failures++;
        $display("FAIL sb_missing expected activity in cycle %0d not shown by DUT", sb_q[0].cyc_no);
        void'(sb_q.pop_front());
      end
      pres = s_cyc_o | m0_ack_o | m1_ack_o | m0_err_o | m1_err_o;
      if (pres) begin
        checks++;
        if (sb_q.size() == 0 || sb_q[0].cyc_no != cycle_no) begin
          failures++;
          $display("FAIL sb_unexpected cycle %0d actual cyc=%b ack=%b%b err=%b%b required no activity",
                   cycle_no, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o);
        end else begin
          e = sb_q.pop_front();
          if (s_cyc_o !== e.cyc || s_stb_o !== e.stb || s_we_o !== e.we || s_sel_o !== e.sel ||
              s_adr_o !== e.adr || s_dat_o !== e.wdat || m0_dat_o !== e.rdat || m1_dat_o !== e.rdat ||
              m0_ack_o !== e.ack0 || m1_ack_o !== e.ack1 || m0_err_o !== e.err0 || m1_err_o !== e.err1) begin
            failures++;
            $display("FAIL sb_cmp cycle %0d actual cyc/stb/we=%b%b%b ack=%b%b err=%b%b adr=%h wdat=%h rdat=%h%h required cyc/stb/we=%b%b%b ack=%b%b err=%b%b adr=%h wdat=%h rdat=%h",
                     cycle_no, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                     s_adr_o, s_dat_o, m0_dat_o, m1_dat_o,
                     e.cyc, e.stb, e.we, e.ack0, e.ack1, e.err0, e.err1, e.adr, e.wdat, e.rdat);
          end
        end
      end
    end
  end

  initial begin : stim
    int bad;
    int pulses;
    int pulse_at;
    for (int i = 0; i < 2; i++) begin
      sel[i] = '0; adr[i] = '0; wdat[i] = '0;
    end

    // Reset: requests and slave responses must not leak through.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, r64());
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, r64());
    #2;
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_s_stb", s_stb_o, 1'b0);
    chk("rst_m0_ack", m0_ack_o, 1'b0);
    chk("rst_m1_ack", m1_ack_o, 1'b0);
    chk("rst_m0_err", m0_err_o, 1'b0);
    chk("rst_m1_err", m1_err_o, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
    rst_i = 1'b1;

    // First tie after reset goes to m0; m1 follows after one idle cycle.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r64());
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r64());
    #2 chk("tie_grant_m0", s_adr_o, adr[0]);
    chk("tie_cyc", s_cyc_o, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    #2 chk("regrant_idle_gap", s_cyc_o, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    #2 chk("regrant_m1", s_adr_o, adr[1]);

    // m1 read acknowledged with known data; m0 sees nothing.
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'hDEADBEEF);
    #2 chk("m1_ack", m1_ack_o, 1'b1);
    chk("m1_rdata", m1_dat_o, 64'hDEADBEEF);
    chk("m0_no_ack", m0_ack_o, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());

    // No preemption: m0 keeps the bus for 10 cycles while m1 waits.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r64());
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'($urandom_range(1)), 1'b0, r64());
      #2 if (s_adr_o !== adr[0] || m1_ack_o !== 1'b0) bad++;
    end
    chk("hold_m0_cycles_bad", 64'(bad), 64'd0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    #2 chk("release_idle", s_cyc_o, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    #2 chk("release_grant_m1", s_adr_o, adr[1]);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());

`ifdef WB_ARB_TIMEOUT_EN
    // Silent slave: exactly one error pulse, four cycles after the first strobe.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r64());
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 7; k++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r64());
      #2 if (m0_err_o === 1'b1) begin pulses++; pulse_at = k; end
    end
    chk("timeout_pulses", 64'(pulses), 64'd1);
    chk("timeout_when", 64'(pulse_at), 64'd4);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
`endif

    // Reset during an m1 write drops the bus at once; m0 then wins the tie.
    force_we = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r64());
    #2 chk("pre_rst_cyc", s_cyc_o, 1'b1);
    #1 rst_i = 1'b0;
    owner = -1; last_owner = 1; wd = 0;
    sb_q.delete();
    #1 chk("async_rst_cyc", s_cyc_o, 1'b0);
    chk("async_rst_stb", s_stb_o, 1'b0);
    force_we = 1'b0;
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r64());
    rst_i = 1'b1;
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r64());
    #2 chk("post_rst_tie_m0", s_adr_o, adr[0]);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());

    // Random traffic: masters hold cyc for random bursts, slave answers randomly.
    rc = 2'b00;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (rc[i]) rc[i] = ($urandom_range(7) != 0);
        else       rc[i] = ($urandom_range(2) == 0);
      end
      apply(rc[0], rc[1], 1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
            1'($urandom_range(3) == 0), 1'($urandom_range(15) == 0), r64());
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r64());
    @(negedge clk);
    #1;
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
